// File: rtl/sram_rr_arbiter.sv
// Two-master arbiter in front of a single-port SRAM with 1-cycle read latency.
// Round-robin or fixed-priority grant; read data is steered back to the granted master and held.
module sram_rr_arbiter #(
  parameter int unsigned LEN_ADDR   = 64,
  parameter int unsigned LEN_DATA   = 64,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_ena,
  input  logic [LEN_ADDR-1:0]   m0_addra,
  input  logic [LEN_DATA-1:0]   m0_dina,
  input  logic [LEN_DATA/8-1:0] m0_wea,
  output logic [LEN_DATA-1:0]   m0_douta,
  output logic                  m0_rvalid,
  output logic                  m0_stall,
  input  logic                  m1_ena,
  input  logic [LEN_ADDR-1:0]   m1_addra,
  input  logic [LEN_DATA-1:0]   m1_dina,
  input  logic [LEN_DATA/8-1:0] m1_wea,
  output logic [LEN_DATA-1:0]   m1_douta,
  output logic                  m1_rvalid,
  output logic                  m1_stall,
  output logic                  s_ena,
  output logic [LEN_ADDR-1:0]   s_addra,
  output logic [LEN_DATA-1:0]   s_dina,
  output logic [LEN_DATA/8-1:0] s_wea,
  input  logic [LEN_DATA-1:0]   s_douta
);

  typedef enum logic {
    SEL_M0 = 1'b0,
    SEL_M1 = 1'b1
  } sel_e;

  sel_e                last_grant_q, last_grant_d;
  sel_e                resp_sel_q, resp_sel_d;
  logic                resp_valid_q, resp_valid_d;
  logic [LEN_DATA-1:0] hold0_q, hold0_d;
  logic [LEN_DATA-1:0] hold1_q, hold1_d;

  logic grant0, grant1, grant_any;

  // Request side: grant and slave mux depend only on requests and last_grant_q.
  always_comb begin
    grant0    = m0_ena & (~m1_ena | (FIXED_PRIO != 0) | (last_grant_q == SEL_M1));
    grant1    = m1_ena & ~grant0;
    grant_any = grant0 | grant1;

    m0_stall  = m0_ena & ~grant0;
    m1_stall  = m1_ena & ~grant1;

    s_ena     = 1'b0;
    s_addra   = '0;
    s_dina    = '0;
    s_wea     = '0;
    if (grant0) begin
      s_ena   = 1'b1;
      s_addra = m0_addra;
      s_dina  = m0_dina;
      s_wea   = m0_wea;
    end else if (grant1) begin
      s_ena   = 1'b1;
      s_addra = m1_addra;
      s_dina  = m1_dina;
      s_wea   = m1_wea;
    end
  end

  // Response side: an in-flight response is suppressed while reset is asserted.
  always_comb begin
    m0_rvalid    = resp_valid_q & ~rst & (resp_sel_q == SEL_M0);
    m1_rvalid    = resp_valid_q & ~rst & (resp_sel_q == SEL_M1);
    m0_douta     = m0_rvalid ? s_douta : hold0_q;
    m1_douta     = m1_rvalid ? s_douta : hold1_q;

    hold0_d      = m0_rvalid ? s_douta : hold0_q;
    hold1_d      = m1_rvalid ? s_douta : hold1_q;

    resp_valid_d = grant_any;
    resp_sel_d   = grant1 ? SEL_M1 : SEL_M0;

    last_grant_d = last_grant_q;
    if (grant0) begin
      last_grant_d = SEL_M0;
    end else if (grant1) begin
      last_grant_d = SEL_M1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= SEL_M1;
      resp_sel_q   <= SEL_M0;
      resp_valid_q <= 1'b0;
      hold0_q      <= '0;
      hold1_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      resp_sel_q   <= resp_sel_d;
      resp_valid_q <= resp_valid_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own SRAM slave; responses are predicted into a queue and checked on return.
module tb_sram_rr_arbiter;

  localparam int unsigned LA = 64;
  localparam int unsigned LD = 64;
  localparam int unsigned LW = LD / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_ena, m1_ena;
  logic [LA-1:0] m0_addra, m1_addra;
  logic [LD-1:0] m0_dina, m1_dina;
  logic [LW-1:0] m0_wea, m1_wea;

  logic          m0_rvalid_w [2];
  logic          m1_rvalid_w [2];
  logic          m0_stall_w  [2];
  logic          m1_stall_w  [2];
  logic          s_ena_w     [2];
  logic [LD-1:0] m0_douta_w  [2];
  logic [LD-1:0] m1_douta_w  [2];
  logic [LD-1:0] s_dina_w    [2];
  logic [LD-1:0] s_douta_w   [2];
  logic [LA-1:0] s_addra_w   [2];
  logic [LW-1:0] s_wea_w     [2];

  sram_rr_arbiter #(.LEN_ADDR(LA), .LEN_DATA(LD), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .m0_ena(m0_ena), .m0_addra(m0_addra), .m0_dina(m0_dina), .m0_wea(m0_wea),
    .m0_douta(m0_douta_w[0]), .m0_rvalid(m0_rvalid_w[0]), .m0_stall(m0_stall_w[0]),
    .m1_ena(m1_ena), .m1_addra(m1_addra), .m1_dina(m1_dina), .m1_wea(m1_wea),
    .m1_douta(m1_douta_w[0]), .m1_rvalid(m1_rvalid_w[0]), .m1_stall(m1_stall_w[0]),
    .s_ena(s_ena_w[0]), .s_addra(s_addra_w[0]), .s_dina(s_dina_w[0]), .s_wea(s_wea_w[0]),
    .s_douta(s_douta_w[0])
  );

  sram_rr_arbiter #(.LEN_ADDR(LA), .LEN_DATA(LD), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .m0_ena(m0_ena), .m0_addra(m0_addra), .m0_dina(m0_dina), .m0_wea(m0_wea),
    .m0_douta(m0_douta_w[1]), .m0_rvalid(m0_rvalid_w[1]), .m0_stall(m0_stall_w[1]),
    .m1_ena(m1_ena), .m1_addra(m1_addra), .m1_dina(m1_dina), .m1_wea(m1_wea),
    .m1_douta(m1_douta_w[1]), .m1_rvalid(m1_rvalid_w[1]), .m1_stall(m1_stall_w[1]),
    .s_ena(s_ena_w[1]), .s_addra(s_addra_w[1]), .s_dina(s_dina_w[1]), .s_wea(s_wea_w[1]),
    .s_douta(s_douta_w[1])
  );

  function automatic logic [63:0] init_word(input int unsigned i);
    return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0000_0001_0001_0001);
  endfunction

  // Read-first SRAM slave per instance.
  for (genvar g = 0; g < 2; g++) begin : g_slv
    logic [63:0] mem [256];
    logic [63:0] rd;
    initial for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    assign s_douta_w[g] = rd;
    always @(posedge clk) begin
      if (s_ena_w[g]) begin
        rd <= mem[s_addra_w[g][7:0]];
        for (int b = 0; b < 8; b++)
          if (s_wea_w[g][b]) mem[s_addra_w[g][7:0]][b*8 +: 8] <= s_dina_w[g][b*8 +: 8];
      end
    end
  end

  typedef struct {
    int unsigned inst;
    logic        sel;
    logic [63:0] data;
  } resp_t;

  resp_t       exp_q [$];
  logic [63:0] ref_mem [2][256];
  logic        lg_m    [2];
  logic [63:0] hold_m  [2][2];
  logic        gnt0_m  [2];
  logic        obs_st0 [2];
  logic        obs_st1 [2];
  logic        obs_rv0 [2];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_ena = 1'b0; m0_addra = '0; m0_dina = '0; m0_wea = '0;
    m1_ena = 1'b0; m1_addra = '0; m1_dina = '0; m1_wea = '0;
  endtask

  // One clock cycle: check returning responses and this cycle's grant, then advance the model.
  task automatic step();
    resp_t       e;
    logic        g0, g1, rv0, rv1;
    logic [63:0] d0, d1, ad, din, sa;
    logic [7:0]  we;
    #2;
    for (int unsigned k = 0; k < 2; k++) begin
      rv0 = 1'b0; rv1 = 1'b0;
      d0 = hold_m[k][0]; d1 = hold_m[k][1];
      if (exp_q.size() > 0 && exp_q[0].inst == k) begin
        e = exp_q.pop_front();
        if (!rst) begin
          if (e.sel) begin rv1 = 1'b1; d1 = e.data; end
          else       begin rv0 = 1'b1; d0 = e.data; end
        end
      end
      obs_rv0[k] = m0_rvalid_w[k];
      chk($sformatf("i%0d_m0_rvalid", k), 64'(m0_rvalid_w[k]), 64'(rv0));
      chk($sformatf("i%0d_m1_rvalid", k), 64'(m1_rvalid_w[k]), 64'(rv1));
      if (!rst) begin
        chk($sformatf("i%0d_m0_douta", k), m0_douta_w[k], d0);
        chk($sformatf("i%0d_m1_douta", k), m1_douta_w[k], d1);
        hold_m[k][0] = d0;
        hold_m[k][1] = d1;
      end

      g0 = m0_ena & (!m1_ena || k == 1 || lg_m[k]);
      g1 = m1_ena & !g0;
      gnt0_m[k]  = g0;
      obs_st0[k] = m0_stall_w[k];
      obs_st1[k] = m1_stall_w[k];
      chk($sformatf("i%0d_m0_stall", k), 64'(m0_stall_w[k]), 64'(m0_ena & !g0));
      chk($sformatf("i%0d_m1_stall", k), 64'(m1_stall_w[k]), 64'(m1_ena & !g1));
      ad  = g0 ? m0_addra : (g1 ? m1_addra : '0);
      din = g0 ? m0_dina  : (g1 ? m1_dina  : '0);
      we  = g0 ? m0_wea   : (g1 ? m1_wea   : '0);
      sa  = s_addra_w[k];
      chk($sformatf("i%0d_s_ena", k), 64'(s_ena_w[k]), 64'(g0 | g1));
      chk($sformatf("i%0d_s_addra", k), sa, ad);
      chk($sformatf("i%0d_s_dina", k), s_dina_w[k], din);
      chk($sformatf("i%0d_s_wea", k), 64'(s_wea_w[k]), 64'(we));

      if (g0 | g1) begin
        if (!rst) exp_q.push_back('{inst: k, sel: g1, data: ref_mem[k][ad[7:0]]});
        for (int b = 0; b < 8; b++)
          if (we[b]) ref_mem[k][ad[7:0]][b*8 +: 8] = din[b*8 +: 8];
        lg_m[k] = g1;
      end
      if (rst) begin
        lg_m[k] = 1'b1;
        hold_m[k][0] = '0;
        hold_m[k][1] = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          cnt;
    logic [63:0] w;
    for (int unsigned k = 0; k < 2; k++) begin
      for (int unsigned i = 0; i < 256; i++) ref_mem[k][i] = init_word(i);
      lg_m[k] = 1'b1;
      hold_m[k][0] = '0;
      hold_m[k][1] = '0;
    end
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;

    // Single master 0 read, then watch the response and hold.
    m0_ena = 1'b1; m0_addra = 64'h10;
    step();
    idle();
    step();
    step();

    // Continuous contention; each master advances only when granted by the RR instance.
    m0_ena = 1'b1; m0_addra = 64'h01;
    m1_ena = 1'b1; m1_addra = 64'h40;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (obs_st0[0]) cnt++;
      if (gnt0_m[0]) m0_addra = m0_addra + 64'h1;
      else           m1_addra = m1_addra + 64'h1;
    end
    chk("rr_m0_stall_count", 64'(cnt), 64'd4);
    idle();
    step();

    // Fixed priority: m1 starves for 4 cycles, served as soon as m0 withdraws.
    m0_ena = 1'b1; m0_addra = 64'h30;
    m1_ena = 1'b1; m1_addra = 64'h31;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (obs_st1[1]) cnt++;
    end
    chk("fp_m1_stall_count", 64'(cnt), 64'd4);
    m0_ena = 1'b0;
    step();
    chk("fp_m1_served", 64'(obs_st1[1]), 64'd0);
    idle();
    step();

    // Partial write from m1, read back from m0.
    m1_ena = 1'b1; m1_addra = 64'h20; m1_dina = 64'h0000_0000_DEAD_BEEF; m1_wea = 8'h0F;
    step();
    idle();
    m0_ena = 1'b1; m0_addra = 64'h20;
    step();
    idle();
    w = init_word(32'h20);
    w[31:0] = 32'hDEAD_BEEF;
    chk("wr_readback_m0", m0_douta_w[0], w);
    step();
    step();

    // Read then idle: rvalid only once, data held.
    m0_ena = 1'b1; m0_addra = 64'h11;
    step();
    idle();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs_rv0[0]) cnt++;
    end
    chk("m0_rvalid_pulses", 64'(cnt), 64'd1);

    // Reset right after a grant drops the response and restores m0 priority.
    m0_ena = 1'b1; m0_addra = 64'h12;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_m0_douta", m0_douta_w[0], 64'h0);
    m0_ena = 1'b1; m0_addra = 64'h13;
    m1_ena = 1'b1; m1_addra = 64'h14;
    step();
    chk("post_rst_m0_wins", 64'(obs_st0[0]), 64'd0);
    chk("post_rst_m1_stalled", 64'(obs_st1[0]), 64'd1);
    idle();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
